// File: rtl/preg_freelist_pkg.sv
// preg_freelist_pkg: shared physical-register types used by decode, issue and commit
package preg_freelist_pkg;
    localparam int NUM_PREGS = 64;
    localparam int NUM_AREGS = 16;
    localparam int PW = $clog2(NUM_PREGS);
    typedef logic [PW-1:0] preg_t;
    typedef logic [PW:0] fl_ptr_t;
endpackage

// File: rtl/preg_freelist_if.sv
// preg_freelist_if: decode alloc, commit free/retire and flush bundle for the preg free list
interface preg_freelist_if;
    import preg_freelist_pkg::*;
    logic [1:0] alloc_count;
    logic       alloc_grant;
    preg_t      preg1;
    preg_t      preg2;
    logic [1:0] free_valid;
    preg_t      free_preg1;
    preg_t      free_preg2;
    logic [1:0] commit_count;
    logic       flush;
    fl_ptr_t    num_free;
    logic       error;
    modport master (
        output alloc_count, free_valid, free_preg1, free_preg2, commit_count, flush,
        input  alloc_grant, preg1, preg2, num_free, error
    );
    modport slave (
        input  alloc_count, free_valid, free_preg1, free_preg2, commit_count, flush,
        output alloc_grant, preg1, preg2, num_free, error
    );
endinterface

// File: rtl/preg_freelist.sv
// preg_freelist: circular free list granting up to 2 pregs/cycle with commit-point rollback on flush
module preg_freelist #(
    parameter int NUM_AREGS = preg_freelist_pkg::NUM_AREGS
) (
    input  logic                  clk,
    input  logic                  reset,
    preg_freelist_if.slave        fl
);
    import preg_freelist_pkg::*;
    localparam int NFREE_INIT = NUM_PREGS - NUM_AREGS;
    localparam logic [PW+1:0] LIMIT = NUM_PREGS[PW+1:0];
    preg_t       r_mem [NUM_PREGS];
    fl_ptr_t     r_head;
    fl_ptr_t     r_arch;
    fl_ptr_t     r_tail;
    logic        r_err;
    fl_ptr_t     w_num_free;
    fl_ptr_t     w_uncommitted;
    fl_ptr_t     w_head_nxt;
    logic [1:0]  w_nfree;
    logic [PW+1:0] w_sum;
    logic        w_grant;
    logic        w_overflow;
    logic        w_overcommit;
    preg_t       w_head_idx;
    preg_t       w_slot2_idx;
    assign w_num_free    = r_tail - r_head;
    assign w_uncommitted = r_head - r_arch;
    assign w_nfree       = {1'b0, fl.free_valid[0]} + {1'b0, fl.free_valid[1]};
    assign w_sum         = {1'b0, w_num_free} + {{PW{1'b0}}, w_nfree};
    assign w_overflow    = w_sum > LIMIT;
    assign w_overcommit  = w_uncommitted < fl_ptr_t'(fl.commit_count);
    assign w_grant       = !fl.flush && !reset && (w_num_free >= fl_ptr_t'(fl.alloc_count));
    assign w_head_idx    = r_head[PW-1:0];
    // slot 2 lands right behind slot 1 only when slot 1 is also returning
    assign w_slot2_idx   = r_tail[PW-1:0] + preg_t'(fl.free_valid[0]);
    always_comb begin
        w_head_nxt = fl.flush ? r_arch + fl_ptr_t'(fl.commit_count)
                   : w_grant  ? r_head + fl_ptr_t'(fl.alloc_count)
                   : r_head;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_PREGS; i++) r_mem[i] <= preg_t'(NUM_AREGS + i);
            r_head <= '0;
            r_arch <= '0;
            r_tail <= fl_ptr_t'(NFREE_INIT);
            r_err  <= 1'b0;
        end else begin
            if (fl.free_valid[0]) r_mem[r_tail[PW-1:0]] <= fl.free_preg1;
            if (fl.free_valid[1]) r_mem[w_slot2_idx] <= fl.free_preg2;
            r_head <= w_head_nxt;
            r_arch <= r_arch + fl_ptr_t'(fl.commit_count);
            r_tail <= r_tail + fl_ptr_t'(w_nfree);
            r_err  <= r_err | w_overflow | w_overcommit | (&fl.alloc_count);
        end
    end
    assign fl.alloc_grant = w_grant;
    assign fl.preg1       = r_mem[w_head_idx];
    assign fl.preg2       = r_mem[w_head_idx + preg_t'(1)];
    assign fl.num_free    = w_num_free;
    assign fl.error       = r_err;
endmodule

// File: tb/tb_preg_freelist.sv
// tb_preg_freelist: directed stimulus with a queued scoreboard checked by an independent monitor
module tb_preg_freelist;
    import preg_freelist_pkg::*;
    typedef struct {
        int      id;
        bit      sel;
        logic [4:0] m;
        logic    g;
        preg_t   p1;
        preg_t   p2;
        fl_ptr_t nf;
        logic    e;
    } exp_t;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int vectors = 0;
    int miscompares = 0;
    int sid = 0;
    exp_t q[$];
    preg_freelist_if fa();
    preg_freelist_if fb();
    preg_freelist u_a (.clk(clk), .reset(reset), .fl(fa.slave));
    preg_freelist #(.NUM_AREGS(1)) u_b (.clk(clk), .reset(reset), .fl(fb.slave));
    always #5 clk = ~clk;
    task automatic chk(input int id, input string f, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL step %0d %s: got %0d expected %0d", id, f, got, exp);
        end
    endtask
    always @(negedge clk) begin
        if (q.size() != 0) begin
            exp_t x;
            logic g, e;
            preg_t p1, p2;
            fl_ptr_t nf;
            x  = q.pop_front();
            g  = x.sel ? fb.alloc_grant : fa.alloc_grant;
            p1 = x.sel ? fb.preg1 : fa.preg1;
            p2 = x.sel ? fb.preg2 : fa.preg2;
            nf = x.sel ? fb.num_free : fa.num_free;
            e  = x.sel ? fb.error : fa.error;
            if (x.m[4]) chk(x.id, "alloc_grant", 32'(g), 32'(x.g));
            if (x.m[3]) chk(x.id, "preg1", 32'(p1), 32'(x.p1));
            if (x.m[2]) chk(x.id, "preg2", 32'(p2), 32'(x.p2));
            if (x.m[1]) chk(x.id, "num_free", 32'(nf), 32'(x.nf));
            if (x.m[0]) chk(x.id, "error", 32'(e), 32'(x.e));
        end
    end
    task automatic idle();
        fa.alloc_count = 0; fa.free_valid = 0; fa.free_preg1 = 0; fa.free_preg2 = 0;
        fa.commit_count = 0; fa.flush = 0;
        fb.alloc_count = 0; fb.free_valid = 0; fb.free_preg1 = 0; fb.free_preg2 = 0;
        fb.commit_count = 0; fb.flush = 0;
    endtask
    task automatic do_reset();
        @(posedge clk); #1;
        idle();
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask
    task automatic step(input bit sel, input logic [1:0] ac, input logic [1:0] fv,
                        input preg_t f1, input preg_t f2, input logic [1:0] cc, input logic fl,
                        input logic [4:0] m, input logic g, input preg_t p1, input preg_t p2,
                        input fl_ptr_t nf, input logic e);
        @(posedge clk); #1;
        idle();
        if (sel) begin
            fb.alloc_count = ac; fb.free_valid = fv; fb.free_preg1 = f1; fb.free_preg2 = f2;
            fb.commit_count = cc; fb.flush = fl;
        end else begin
            fa.alloc_count = ac; fa.free_valid = fv; fa.free_preg1 = f1; fa.free_preg2 = f2;
            fa.commit_count = cc; fa.flush = fl;
        end
        q.push_back('{id: sid, sel: sel, m: m, g: g, p1: p1, p2: p2, nf: nf, e: e});
        sid++;
    endtask
    initial begin
        idle();
        do_reset();
        for (int k = 0; k < 24; k++)
            step(0, 2, 0, 0, 0, 0, 0, 5'b11111, 1, preg_t'(16 + 2*k), preg_t'(17 + 2*k), fl_ptr_t'(48 - 2*k), 0);
        step(0, 1, 2'b00, 0, 0, 0, 0, 5'b10011, 0, 0, 0, 7'd0, 0);
        step(0, 1, 2'b11, 6'd5, 6'd9, 0, 0, 5'b10011, 0, 0, 0, 7'd0, 0);
        step(0, 2, 2'b00, 0, 0, 0, 0, 5'b11111, 1, 6'd5, 6'd9, 7'd2, 0);
        step(0, 0, 2'b10, 0, 6'd33, 0, 0, 5'b10011, 1, 0, 0, 7'd0, 0);
        step(0, 1, 2'b00, 0, 0, 0, 0, 5'b11011, 1, 6'd33, 0, 7'd1, 0);
        step(0, 0, 2'b00, 0, 0, 0, 0, 5'b10011, 1, 0, 0, 7'd0, 0);
        do_reset();
        step(0, 2, 0, 0, 0, 0, 0, 5'b11111, 1, 6'd16, 6'd17, 7'd48, 0);
        step(0, 2, 0, 0, 0, 0, 0, 5'b11111, 1, 6'd18, 6'd19, 7'd46, 0);
        step(0, 0, 0, 0, 0, 2, 0, 5'b10011, 1, 0, 0, 7'd44, 0);
        step(0, 2, 0, 0, 0, 0, 1, 5'b10011, 0, 0, 0, 7'd44, 0);
        step(0, 1, 0, 0, 0, 0, 0, 5'b11011, 1, 6'd18, 0, 7'd46, 0);
        do_reset();
        for (int k = 0; k < 80; k++)
            step(0, 2, (k != 0) ? 2'b11 : 2'b00,
                 preg_t'(16 + (2*(k+47)) % 48), preg_t'(17 + (2*(k+47)) % 48),
                 (k != 0) ? 2'd2 : 2'd0, 0, 5'b11111, 1,
                 preg_t'(16 + (2*k) % 48), preg_t'(17 + (2*k) % 48),
                 (k != 0) ? 7'd46 : 7'd48, 0);
        step(0, 0, 0, 0, 0, 2, 0, 5'b00011, 0, 0, 0, 7'd46, 0);
        step(0, 0, 0, 0, 0, 1, 0, 5'b00011, 0, 0, 0, 7'd46, 0);
        step(0, 0, 0, 0, 0, 0, 0, 5'b00011, 0, 0, 0, 7'd46, 1);
        step(0, 0, 0, 0, 0, 0, 0, 5'b00001, 0, 0, 0, 7'd0, 1);
        do_reset();
        step(0, 0, 0, 0, 0, 0, 0, 5'b11111, 1, 6'd16, 6'd17, 7'd48, 0);
        step(0, 3, 0, 0, 0, 0, 0, 5'b10001, 1, 0, 0, 7'd0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 5'b00011, 0, 0, 0, 7'd45, 1);
        do_reset();
        step(1, 0, 0, 0, 0, 0, 0, 5'b11111, 1, 6'd1, 6'd2, 7'd63, 0);
        step(1, 0, 2'b11, 6'd1, 6'd2, 0, 0, 5'b00011, 0, 0, 0, 7'd63, 0);
        step(1, 0, 0, 0, 0, 0, 0, 5'b00001, 0, 0, 0, 7'd0, 1);
        step(1, 0, 0, 0, 0, 0, 0, 5'b00001, 0, 0, 0, 7'd0, 1);
        do_reset();
        step(1, 0, 0, 0, 0, 0, 0, 5'b00011, 0, 0, 0, 7'd63, 0);
        for (int i = 0; i < 10 && q.size() != 0; i++) @(posedge clk);
        if (q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
